// File: rtl/tdc_pulse_pair_gen.sv
// Start/stop pulse-pair generator driving a TDC for self-test and calibration.
// Emits start, then stop D cycles later, each W cycles wide; optional auto-repeat.
module tdc_pulse_pair_gen #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_i,
    input  logic [7:0]       delay_i,
    input  logic [1:0]       width_i,
    input  logic             repeat_i,
    input  logic             abort_i,
    input  logic             cnt_clr_i,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pair_cnt_o
);

    localparam int unsigned D_W   = 8;
    localparam int unsigned W_W   = 3;
    localparam int unsigned T_W   = 9;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [D_W-1:0]     d_q, d_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [T_W-1:0]     last_t_q;
    logic [T_W-1:0]     pair_len_d;
    logic               act_d;

    assign last_t_q = {1'b0, d_q} + T_W'(w_q) - T_W'(1);

    // Next-state: abort dominates; D/W only latched on trigger acceptance
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        d_d     = d_q;
        w_d     = w_q;
        gap_d   = gap_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig_i) begin
                        d_d     = delay_i;
                        w_d     = {1'b0, width_i} + W_W'(1);
                        t_d     = '0;
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (t_q == last_t_q) begin
                        gap_d   = '0;
                        state_d = repeat_i ? S_GAP : S_IDLE;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        t_d     = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are precomputed from the next state so they can be flopped
    always_comb begin
        act_d      = (state_d == S_ACTIVE);
        pair_len_d = {1'b0, d_d} + T_W'(w_d);
        start_d    = act_d && (t_d < T_W'(w_d));
        stop_d     = act_d && (t_d >= T_W'(d_d)) && (t_d < pair_len_d);
        done_d     = act_d && (t_d == pair_len_d - T_W'(1));
        busy_d     = (state_d != S_IDLE);
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (done_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            d_q     <= '0;
            w_q     <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
            w_q     <= w_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pair_cnt_o = cnt_q;

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Directed bench for tdc_pulse_pair_gen: vector table of single shots plus
// hand-written repeat, retrigger, abort, reset and counter sequences.
module tb_tdc_pulse_pair_gen;

    logic       clk;
    logic       rst;
    logic       trig_i;
    logic [7:0] delay_i;
    logic [1:0] width_i;
    logic       repeat_i;
    logic       abort_i;
    logic       cnt_clr_i;
    logic       start_o;
    logic       stop_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] pair_cnt_o;

    tdc_pulse_pair_gen #(.GAP_CYCLES(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_i     (trig_i),
        .delay_i    (delay_i),
        .width_i    (width_i),
        .repeat_i   (repeat_i),
        .abort_i    (abort_i),
        .cnt_clr_i  (cnt_clr_i),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pair_cnt_o (pair_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // Per-cycle capture of one sequence; index = cycle number after trigger edge
    logic st_a [0:511];
    logic sp_a [0:511];
    logic dn_a [0:511];
    logic bz_a [0:511];

    localparam int K_START = 0;
    localparam int K_STOP  = 1;
    localparam int K_DONE  = 2;
    localparam int K_BUSY  = 3;

    typedef struct {
        int d;
        int wi;
        int s_first;
        int s_last;
        int p_first;
        int p_last;
        int done_c;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_bit(input int k, input int c);
        case (k)
            K_START: return st_a[c];
            K_STOP:  return sp_a[c];
            K_DONE:  return dn_a[c];
            default: return bz_a[c];
        endcase
    endfunction

    function automatic int first_hi(input int k, input int n);
        for (int c = 1; c <= n; c++) if (get_bit(k, c)) return c;
        return 0;
    endfunction

    function automatic int last_hi(input int k, input int n);
        for (int c = n; c >= 1; c--) if (get_bit(k, c)) return c;
        return 0;
    endfunction

    function automatic int cnt_hi(input int k, input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) if (get_bit(k, c)) s++;
        return s;
    endfunction

    function automatic int first_lo(input int k, input int n);
        for (int c = 1; c <= n; c++) if (!get_bit(k, c)) return c;
        return 0;
    endfunction

    function automatic int nth_rise(input int k, input int n, input int idx);
        int r = 0;
        for (int c = 1; c <= n; c++) begin
            if (get_bit(k, c) && !get_bit(k, c - 1)) begin
                if (r == idx) return c;
                r++;
            end
        end
        return 0;
    endfunction

    function automatic int rise_cnt(input int k, input int n);
        int r = 0;
        for (int c = 1; c <= n; c++) if (get_bit(k, c) && !get_bit(k, c - 1)) r++;
        return r;
    endfunction

    // Trigger at edge 0, then record cycles 1..ncyc; scheduled inputs apply
    // during the named cycle (0 = never)
    task automatic run_seq(input int d, input int wi, input logic rep, input int ncyc,
                           input int drop_rep_c, input int trig2_c, input int abort_c,
                           input int clr_c);
        for (int c = 0; c < 512; c++) begin
            st_a[c] = 1'b0; sp_a[c] = 1'b0; dn_a[c] = 1'b0; bz_a[c] = 1'b0;
        end
        delay_i  = 8'(d);
        width_i  = 2'(wi);
        repeat_i = rep;
        trig_i   = 1'b1;
        @(posedge clk); #1;
        trig_i = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            st_a[c] = start_o;
            sp_a[c] = stop_o;
            dn_a[c] = done_o;
            bz_a[c] = busy_o;
            trig_i    = (c == trig2_c);
            if (trig2_c != 0 && c >= trig2_c) delay_i = 8'd1;
            repeat_i  = (drop_rep_c != 0 && c >= drop_rep_c) ? 1'b0 : rep;
            abort_i   = (c == abort_c);
            cnt_clr_i = (c == clr_c);
            @(posedge clk); #1;
        end
        trig_i = 1'b0; repeat_i = 1'b0; abort_i = 1'b0; cnt_clr_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int n;
        rst = 1'b1; trig_i = 1'b0; delay_i = '0; width_i = '0;
        repeat_i = 1'b0; abort_i = 1'b0; cnt_clr_i = 1'b0;

        // {D, width_i, start first/last, stop first/last, done cycle}
        vecs[0] = '{10, 0, 1, 1,  11,  11,  11};
        vecs[1] = '{0,  3, 1, 4,   1,   4,   4};
        vecs[2] = '{2,  3, 1, 4,   3,   6,   6};
        vecs[3] = '{1,  1, 1, 2,   2,   3,   3};
        vecs[4] = '{3,  0, 1, 1,   4,   4,   4};
        vecs[5] = '{255,3, 1, 4, 256, 259, 259};

        #12;
        check("rst_start", int'(start_o), 0);
        check("rst_stop",  int'(stop_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_done",  int'(done_o), 0);
        check("rst_cnt",   int'(pair_cnt_o), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single-shot vectors
        foreach (vecs[i]) begin
            n = vecs[i].done_c + 3;
            run_seq(vecs[i].d, vecs[i].wi, 1'b0, n, 0, 0, 0, 0);
            exp_cnt = (exp_cnt + 1) % 256;
            check($sformatf("v%0d_start_first", i), first_hi(K_START, n), vecs[i].s_first);
            check($sformatf("v%0d_start_last", i),  last_hi(K_START, n), vecs[i].s_last);
            check($sformatf("v%0d_start_len", i),   cnt_hi(K_START, n),
                  vecs[i].s_last - vecs[i].s_first + 1);
            check($sformatf("v%0d_stop_first", i),  first_hi(K_STOP, n), vecs[i].p_first);
            check($sformatf("v%0d_stop_last", i),   last_hi(K_STOP, n), vecs[i].p_last);
            check($sformatf("v%0d_stop_len", i),    cnt_hi(K_STOP, n),
                  vecs[i].p_last - vecs[i].p_first + 1);
            check($sformatf("v%0d_done_cyc", i),    first_hi(K_DONE, n), vecs[i].done_c);
            check($sformatf("v%0d_done_num", i),    cnt_hi(K_DONE, n), 1);
            check($sformatf("v%0d_busy_low", i),    first_lo(K_BUSY, n), vecs[i].done_c + 1);
            check($sformatf("v%0d_cnt", i),         int'(pair_cnt_o), exp_cnt);
        end

        // Repeat: D=5, W=2, period 5+2+16=23; repeat dropped during pair 3
        run_seq(5, 1, 1'b1, 70, 49, 0, 0, 0);
        exp_cnt = (exp_cnt + 3) % 256;
        check("rep_rises",      rise_cnt(K_START, 70), 3);
        check("rep_rise0",      nth_rise(K_START, 70, 0), 1);
        check("rep_rise1",      nth_rise(K_START, 70, 1), 24);
        check("rep_rise2",      nth_rise(K_START, 70, 2), 47);
        check("rep_stop_rise2", nth_rise(K_STOP, 70, 2), 52);
        check("rep_start_hi",   cnt_hi(K_START, 70), 6);
        check("rep_stop_hi",    cnt_hi(K_STOP, 70), 6);
        check("rep_done_num",   cnt_hi(K_DONE, 70), 3);
        check("rep_done_last",  last_hi(K_DONE, 70), 53);
        check("rep_busy_low",   first_lo(K_BUSY, 70), 54);
        check("rep_cnt",        int'(pair_cnt_o), exp_cnt);

        // Trigger with new delay while busy is ignored
        run_seq(255, 0, 1'b0, 262, 0, 50, 0, 0);
        exp_cnt = (exp_cnt + 1) % 256;
        check("tb_start_rises", rise_cnt(K_START, 262), 1);
        check("tb_stop_first",  first_hi(K_STOP, 262), 256);
        check("tb_stop_len",    cnt_hi(K_STOP, 262), 1);
        check("tb_done_cyc",    first_hi(K_DONE, 262), 256);
        check("tb_done_num",    cnt_hi(K_DONE, 262), 1);
        check("tb_busy_low",    first_lo(K_BUSY, 262), 257);
        check("tb_cnt",         int'(pair_cnt_o), exp_cnt);

        // Abort during cycle 5 of a D=20 pair
        run_seq(20, 0, 1'b0, 30, 0, 0, 5, 0);
        check("ab_start_hi",  cnt_hi(K_START, 30), 1);
        check("ab_stop_hi",   cnt_hi(K_STOP, 30), 0);
        check("ab_done_num",  cnt_hi(K_DONE, 30), 0);
        check("ab_busy_low",  first_lo(K_BUSY, 30), 6);
        check("ab_cnt",       int'(pair_cnt_o), exp_cnt);

        // Abort in IDLE blocks a simultaneous trigger
        trig_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        trig_i = 1'b0; abort_i = 1'b0;
        check("abidle_busy",  int'(busy_o), 0);
        check("abidle_start", int'(start_o), 0);
        @(posedge clk); #1;

        // Clear in the same cycle as done wins
        run_seq(0, 0, 1'b0, 4, 0, 0, 0, 0);
        exp_cnt = (exp_cnt + 1) % 256;
        check("clr_pre_cnt", int'(pair_cnt_o), exp_cnt);
        run_seq(0, 0, 1'b0, 4, 0, 0, 0, 1);
        exp_cnt = 0;
        check("clr_done_cyc", first_hi(K_DONE, 4), 1);
        check("clr_cnt",      int'(pair_cnt_o), exp_cnt);

        // 256 back-to-back pairs wrap the counter to 0
        nd = 0;
        delay_i = 8'd0; width_i = 2'd0; trig_i = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1;
            if (done_o) begin
                nd++;
                if (nd == 256) begin
                    check("wrap_cnt_255", int'(pair_cnt_o), 255);
                    trig_i = 1'b0;
                    break;
                end
            end
        end
        trig_i = 1'b0;
        check("wrap_num_pairs", nd, 256);
        @(posedge clk); #1;
        check("wrap_cnt_0", int'(pair_cnt_o), 0);
        run_seq(0, 0, 1'b0, 3, 0, 0, 0, 0);
        check("wrap_cnt_after", int'(pair_cnt_o), 1);

        // Reset asserted while start is high
        delay_i = 8'd10; width_i = 2'd3; trig_i = 1'b1;
        @(posedge clk); #1;
        trig_i = 1'b0;
        check("rstmid_start_pre", int'(start_o), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_start", int'(start_o), 0);
        check("rstmid_busy",  int'(busy_o), 0);
        check("rstmid_cnt",   int'(pair_cnt_o), 0);
        @(negedge clk); rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_o || stop_o || busy_o) nd++;
        end
        check("rstmid_quiet", nd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
